// File: rtl/adc_debug_uart_rx_if.sv
// rtl/adc_debug_uart_rx_if.sv - serial line, enable and byte/strobe outputs of the debug UART receiver
interface adc_debug_uart_rx_if;
    logic       rx_en;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rx_en,
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output rx_en,
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/adc_debug_uart_rx.sv
// rtl/adc_debug_uart_rx.sv - 8N1 debug UART receiver, mid-bit sampled; ADC_DEBUG_UART_RX_PARITY_EN adds even parity
module adc_debug_uart_rx #(
    parameter int BPS_PARA = 50
) (
    input  logic                  clk,
    input  logic                  RST,
    adc_debug_uart_rx_if.master   bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    localparam logic [12:0] HALF_LAST = 13'(BPS_PARA / 2 - 1);
    localparam logic [12:0] FULL_LAST = 13'(BPS_PARA - 1);

    state_t      state, state_next;
    logic [12:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  rx_data_q;
    logic        sync1, rxs, rxs_d;
    logic        sample, load_byte, ferr_set;
    logic        rx_valid_q, frame_err_q;
`ifdef ADC_DEBUG_UART_RX_PARITY_EN
    logic        par_bit, perr_set, parity_err_q;
`endif

    // Synchronizer resets high so an idle line never looks like a start edge.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= bus.rx_in;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        load_byte  = 1'b0;
        ferr_set   = 1'b0;
`ifdef ADC_DEBUG_UART_RX_PARITY_EN
        perr_set   = 1'b0;
`endif
        if (!bus.rx_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   if (rxs_d && !rxs) state_next = START;
                START:  if (cnt == HALF_LAST) begin
                            sample     = 1'b1;
                            state_next = rxs ? IDLE : DATA;
                        end
                DATA:   if (cnt == FULL_LAST) begin
                            sample = 1'b1;
                            if (bit_idx == 3'd7) begin
`ifdef ADC_DEBUG_UART_RX_PARITY_EN
                                state_next = PARITY;
`else
                                state_next = STOP;
`endif
                            end
                        end
                PARITY: if (cnt == FULL_LAST) begin
                            sample     = 1'b1;
                            state_next = STOP;
                        end
                // A low stop bit wins over any parity result.
                STOP:   if (cnt == FULL_LAST) begin
                            sample = 1'b1;
                            if (!rxs) begin
                                ferr_set   = 1'b1;
                                state_next = BREAK;
`ifdef ADC_DEBUG_UART_RX_PARITY_EN
                            end else if (^{shreg, par_bit}) begin
                                perr_set   = 1'b1;
                                state_next = IDLE;
`endif
                            end else begin
                                load_byte  = 1'b1;
                                state_next = IDLE;
                            end
                        end
                BREAK:  if (rxs) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= 13'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            rx_valid_q  <= load_byte;
            frame_err_q <= ferr_set;
            if (state_next != state || sample || state == IDLE)
                cnt <= 13'd0;
            else
                cnt <= cnt + 13'd1;
            if (!bus.rx_en) begin
                shreg   <= 8'h00;
                bit_idx <= 3'd0;
            end else if (state == DATA && sample) begin
                shreg[bit_idx] <= rxs;
                bit_idx        <= bit_idx + 3'd1;
            end else if (state != DATA) begin
                bit_idx <= 3'd0;
            end
            if (load_byte)
                rx_data_q <= shreg;
        end
    end

`ifdef ADC_DEBUG_UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= perr_set;
            if (state == PARITY && sample)
                par_bit <= rxs;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_adc_debug_uart_rx.sv
// tb/tb_adc_debug_uart_rx.sv - directed frame vectors and corner sequences for adc_debug_uart_rx
module tb_adc_debug_uart_rx;
    localparam int BPS = 50;
`ifdef ADC_DEBUG_UART_RX_PARITY_EN
    localparam int LAT = 2 + BPS / 2 + 10 * BPS + 1;
`else
    localparam int LAT = 2 + BPS / 2 + 9 * BPS + 1;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic RST;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   n_valid = 0, n_ferr = 0, n_perr = 0;
    int   last_valid_cyc = 0, last_ferr_cyc = 0, last_perr_cyc = 0;

    adc_debug_uart_rx_if bus();
    adc_debug_uart_rx #(.BPS_PARA(BPS)) dut (.clk(clk), .RST(RST), .bus(bus.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid)   begin n_valid++; last_valid_cyc = cyc; end
        if (bus.frame_err)  begin n_ferr++;  last_ferr_cyc  = cyc; end
        if (bus.parity_err) begin n_perr++;  last_perr_cyc  = cyc; end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b, input int n);
        bus.rx_in = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is always at posedge+1, so consecutive frames abut with no gap.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, output int t0);
        t0 = cyc;
        bit_out(1'b0, BPS);
        for (int i = 0; i < 8; i++) bit_out(d[i], BPS);
`ifdef ADC_DEBUG_UART_RX_PARITY_EN
        bit_out((^d) ^ par_flip, BPS);
`else
        if (par_flip) bit_out(1'b1, 0);
`endif
        bit_out(stop, BPS);
    endtask

    initial begin
        vec_t vecs[5];
        int t0, t1, nv, nf, np;
        logic [7:0] held;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h81, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};

        RST = 1'b1; bus.rx_in = 1'b1; bus.rx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 RST = 1'b0;
        @(posedge clk); #1;
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_parity_err", bus.parity_err, 0);
        check("reset_busy", bus.busy, 0);
        bit_out(1'b1, 1000);
        check("idle_no_strobe", n_valid + n_ferr + n_perr, 0);

        for (int i = 0; i < 5; i++) begin
            nv = n_valid; nf = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, t0);
            bit_out(1'b1, 20);
            check($sformatf("vec%0d_valid_count", i), n_valid - nv, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_count", i), n_ferr - nf, vecs[i].exp_ferr);
            check($sformatf("vec%0d_rx_data", i), bus.rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), bus.busy, 0);
            if (vecs[i].exp_valid != 0) check($sformatf("vec%0d_valid_time", i), last_valid_cyc - t0, LAT);
            if (vecs[i].exp_ferr != 0)  check($sformatf("vec%0d_ferr_time", i), last_ferr_cyc - t0, LAT);
        end

        // Start-bit glitch, then two abutting frames.
        nv = n_valid; nf = n_ferr;
        bit_out(1'b0, 10);
        check("glitch_busy_high", bus.busy, 1);
        bit_out(1'b1, 40);
        check("glitch_busy_low", bus.busy, 0);
        check("glitch_no_strobe", (n_valid - nv) + (n_ferr - nf), 0);
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        check("b2b_first_data", bus.rx_data, 8'h3C);
        check("b2b_first_time", last_valid_cyc - t0, LAT);
        t1 = last_valid_cyc;
        send_frame(8'hC3, 1'b1, 1'b0, t0);
        bit_out(1'b1, 20);
        check("b2b_second_data", bus.rx_data, 8'hC3);
        check("b2b_spacing", last_valid_cyc - t1, 10 * BPS + ((LAT > 2 + BPS / 2 + 9 * BPS + 1) ? BPS : 0));
        check("b2b_valid_count", n_valid - nv, 2);

        // Framing error with the line held low afterwards.
        nv = n_valid; nf = n_ferr; held = bus.rx_data;
        send_frame(8'h55, 1'b0, 1'b0, t0);
        bit_out(1'b0, 300);
        bit_out(1'b1, 100);
        check("ferr_count", n_ferr - nf, 1);
        check("ferr_time", last_ferr_cyc - t0, LAT);
        check("ferr_no_valid", n_valid - nv, 0);
        check("ferr_data_held", bus.rx_data, held);
        bit_out(1'b1, 500);
        check("ferr_no_more_strobe", (n_valid - nv) + (n_ferr - nf), 1);

        // Enable dropped during data bit 3 of 0xFF.
        nv = n_valid; nf = n_ferr;
        bit_out(1'b0, BPS);
        bit_out(1'b1, 3 * BPS + BPS / 2);
        bus.rx_en = 1'b0;
        bit_out(1'b1, 2);
        check("dis_busy_low", bus.busy, 0);
        bit_out(1'b1, 18);
        bus.rx_en = 1'b1;
        bit_out(1'b1, BPS / 2 - 20 + 5 * BPS + 20);
        check("dis_idle", bus.busy, 0);
        check("dis_no_strobe", (n_valid - nv) + (n_ferr - nf), 0);
        send_frame(8'h01, 1'b1, 1'b0, t0);
        bit_out(1'b1, 20);
        check("after_dis_valid", n_valid - nv, 1);
        check("after_dis_data", bus.rx_data, 8'h01);
        check("after_dis_time", last_valid_cyc - t0, LAT);

`ifdef ADC_DEBUG_UART_RX_PARITY_EN
        nv = n_valid; np = n_perr;
        send_frame(8'h03, 1'b1, 1'b1, t0);
        bit_out(1'b1, 20);
        check("perr_count", n_perr - np, 1);
        check("perr_time", last_perr_cyc - t0, LAT);
        check("perr_no_valid", n_valid - nv, 0);
        check("perr_data_held", bus.rx_data, 8'h01);
        send_frame(8'h03, 1'b1, 1'b0, t0);
        bit_out(1'b1, 20);
        check("par_ok_valid", n_valid - nv, 1);
        check("par_ok_data", bus.rx_data, 8'h03);
`else
        np = 0;
        check("no_parity_err", n_perr - np, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_debug_uart_rx.md
# adc_debug_uart_rx

Serial receiver for the ADC debug link. It accepts 8-bit words from an asynchronous 8N1 line, with optional even parity. Bit timing comes from an internal bit-period counter of BPS_PARA clocks per bit, mid-bit aligned. It sits at the receive end of the debug serial interface and delivers each byte as a one-cycle strobe to the debug command logic.

## Interface
- Clock: one clock. Reset: synchronous, active-high.
- BPS_PARA, default 50: clocks per bit period. Legal range 4..8191, matching the 13-bit counter. Even values are recommended.
- clk  input  1  system clock.
- RST  input  1  synchronous active-high reset.
- rx_en  input  1  receiver enable. Low forces IDLE and discards any frame in progress.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last good byte, LSB received first. Holds its value between frames.
- rx_valid  output  1  one-cycle strobe: rx_data was updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- parity_err  output  1  one-cycle strobe: parity mismatch. Constant 0 when parity is compiled out.
- busy  output  1  high in every state except IDLE.

## Operation
- Input conditioning:
  - rx_in passes through a 2-flop synchronizer, then one more register for edge detection.
  - All decisions use the synchronized value rxs.
- The 13-bit counter cnt clears on every state change and on each sample point.
- States and transitions:
  - IDLE: leave when rx_en=1 and a falling edge on rxs is seen (previous 1, current 0) → START.
  - START: sample when cnt = BPS_PARA/2 − 1 (integer division). rxs=1 is a glitch → IDLE, no strobe. rxs=0 → DATA, bit index 0.
  - DATA: sample when cnt = BPS_PARA − 1. Shift rxs into bit[index], LSB first. After index 7 → PARITY if compiled in, else STOP.
  - PARITY: sample when cnt = BPS_PARA − 1 and store the parity bit → STOP.
  - STOP: sample when cnt = BPS_PARA − 1.
    - rxs=1 and parity OK: load rx_data, pulse rx_valid → IDLE.
    - rxs=1 and parity bad: pulse parity_err, rx_data unchanged → IDLE.
    - rxs=0: pulse frame_err, rx_data unchanged → BREAK. Frame error takes precedence over parity error.
  - BREAK: wait until rxs=1 → IDLE. This keeps a held-low line from producing repeated frames.
- rx_en=0 in any state:
  - Next state is IDLE, cnt is cleared and the partial shift register is discarded.
  - No strobes fire in that cycle.
  - rx_data is held.
- Reset values: state IDLE, cnt 0, rx_data 0x00, rx_valid 0, frame_err 0, parity_err 0, busy 0. Synchronizer flops reset to 1, so no false edge is seen after reset.
- At most one of rx_valid, frame_err, parity_err is high in any cycle.

## Timing
- Reference point T0 is the cycle in which IDLE detects the falling edge. rxs lags rx_in by 2 cycles.
- Start-bit sample: T0 + BPS_PARA/2.
- Data bit k (k=0..7) sample: T0 + BPS_PARA/2 + (k+1)·BPS_PARA.
- Stop-bit sample:
  - Without parity: T0 + BPS_PARA/2 + 9·BPS_PARA.
  - With parity: T0 + BPS_PARA/2 + 10·BPS_PARA.
- Strobes are registered and high in the cycle after the stop sample, for exactly one cycle. rx_data changes in that same cycle.
- Back-to-back frames: IDLE is entered in the strobe cycle, so a start edge immediately after the stop-bit midpoint is accepted.
- busy rises the cycle after T0. It falls with the strobe, or with the glitch reject when leaving START.

## Configuration
- Macro: ADC_DEBUG_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows bit 7.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - A mismatch produces the parity_err strobe.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_err is tied to 0.

## Test plan
All scenarios use BPS_PARA=50, with bits driven for 50 clocks each.
- Reset sequence: hold RST for 3 cycles with rx_in=1 → all outputs 0, busy 0, and no strobe within 1000 idle cycles.
- Single byte: send 0xA5 8N1 → exactly one rx_valid, at T0+476; rx_data=0xA5; no frame_err.
- Start-bit glitch and back-to-back frames:
  - rx_in low for 10 clocks → busy pulses, then returns to IDLE with no strobe.
  - Immediately after, send 0x3C then 0xC3 with no gap → two rx_valid strobes, 500 cycles apart, with the matching data.
- Framing error: send 0x55 with stop bit 0, keep the line low for 300 more clocks, then high → one frame_err, no rx_valid, rx_data unchanged. No further strobe until the next genuine start.
- Enable mid-frame: drop rx_en during data bit 3 of 0xFF, raise it again 20 clocks later while the line is still mid-frame → no strobe, state IDLE. The next clean frame 0x01 is received correctly.
- Parity (macro defined):
  - Send 0x03 with parity bit 1 → parity_err at T0+526, no rx_valid.
  - Send 0x03 with parity bit 0 → rx_valid, rx_data=0x03.
